// File: rtl/fetch_credit_ctrl.sv
// fetch_credit_ctrl
//   Fetch sequencer between the I-cache fetch port and the instruction buffer.
//   It issues fetch-group-aligned request PCs, reserving instruction-buffer
//   entries (credits) before each request. In-order cache responses are tagged
//   with their PC and slot mask and forwarded. On a redirect, responses to
//   requests already in flight are discarded and fetch restarts at the new PC.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   fetch_en_i            permits issue of new requests
//   req_valid_o/ready_i   cache request handshake
//   req_pc_o              aligned request PC
//   rsp_valid_i           in-order cache response (always accepted)
//   rsp_instrs_i          response instructions
//   fe_valid_o, fe_*      group forwarded to the instruction buffer
//   fe_ready_i            buffer ready (checked only; credits guarantee space)
//   deq_fire_i            buffer popped DECODE_WIDTH entries
//   redirect_valid_i/pc_i backend redirect
//   proto_err_o           sticky protocol-error flag

package config_pkg;
    typedef struct packed {
        int unsigned INSTR_PER_FETCH;
        int unsigned ILEN;
        int unsigned PLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{INSTR_PER_FETCH: 4, ILEN: 32, PLEN: 32};
endpackage

module fetch_credit_ctrl #(
    parameter config_pkg::cfg_t  Cfg             = config_pkg::EmptyCfg,
    parameter int unsigned       IB_DEPTH        = 32,
    parameter int unsigned       DECODE_WIDTH    = Cfg.INSTR_PER_FETCH,
    parameter int unsigned       MAX_OUTSTANDING = 4,
    parameter logic [Cfg.PLEN-1:0] RESET_PC      = 'h8000_0000
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     fetch_en_i,
    output logic                                     req_valid_o,
    input  logic                                     req_ready_i,
    output logic [Cfg.PLEN-1:0]                      req_pc_o,
    input  logic                                     rsp_valid_i,
    input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]  rsp_instrs_i,
    output logic                                     fe_valid_o,
    input  logic                                     fe_ready_i,
    output logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]  fe_instrs_o,
    output logic [Cfg.PLEN-1:0]                      fe_pc_o,
    output logic [Cfg.INSTR_PER_FETCH-1:0]           fe_slot_valid_o,
    output logic [Cfg.INSTR_PER_FETCH*Cfg.PLEN-1:0]  fe_pred_npc_o,
    input  logic                                     deq_fire_i,
    input  logic                                     redirect_valid_i,
    input  logic [Cfg.PLEN-1:0]                      redirect_pc_i,
    output logic                                     proto_err_o
);

    localparam int unsigned FW     = Cfg.INSTR_PER_FETCH;
    localparam int unsigned PLEN   = Cfg.PLEN;
    localparam int unsigned IBYTES = Cfg.ILEN / 8;
    localparam int unsigned GBYTES = FW * IBYTES;
    localparam int unsigned OB     = $clog2(GBYTES);
    localparam int unsigned IBB    = $clog2(IBYTES);
    localparam int unsigned CRW    = $clog2(IB_DEPTH + 1);
    localparam int unsigned OUTW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned SUMW   = CRW + 2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e            state, state_next;
    logic [PLEN-1:0]   pc_q, pc_d;
    logic [CRW-1:0]    credit_q, credit_d;
    logic [OUTW-1:0]   out_q, out_d;
    logic [OUTW-1:0]   stale_q, stale_d;
    logic [SUMW-1:0]   credit_sum;
    logic              req_fire, rsp_pop, drop, fwd, overflow;
    logic              proto_err_q;
    logic [PLEN-1:0]   fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PLEN-1:0]   head_pc;
    logic [OB-1:0]     slot_idx;

    function automatic logic [PLEN-1:0] align_pc(input logic [PLEN-1:0] pc);
        return {pc[PLEN-1:OB], {OB{1'b0}}};
    endfunction

    // Clamp credit returns to the buffer depth; anything above it is an error.
    function automatic logic [CRW-1:0] sat_credit(input logic [SUMW-1:0] sum);
        if (sum > SUMW'(IB_DEPTH)) return CRW'(IB_DEPTH);
        return sum[CRW-1:0];
    endfunction

    // ---------------- bookkeeping next-state ----------------
    always_comb begin
        req_fire   = req_valid_o && req_ready_i;
        // A response with nothing outstanding has no PC to pair with: flag it, ignore it.
        rsp_pop    = rsp_valid_i && (out_q != '0);
        drop       = rsp_pop && ((stale_q != '0) || redirect_valid_i);
        fwd        = rsp_pop && !drop;
        out_d      = out_q + OUTW'(req_fire) - OUTW'(rsp_pop);
        credit_sum = SUMW'(credit_q)
                   + (drop       ? SUMW'(FW)           : '0)
                   + (deq_fire_i ? SUMW'(DECODE_WIDTH) : '0)
                   - (req_fire   ? SUMW'(FW)           : '0);
        overflow   = 1'b0;
        pc_d       = pc_q;
        stale_d    = stale_q;
        credit_d   = credit_q;
        if (redirect_valid_i) begin
            // Everything still in flight (including a request firing now) is stale;
            // its credits stay reserved until the response arrives and is dropped.
            stale_d  = out_d;
            credit_d = CRW'(IB_DEPTH) - CRW'(FW) * CRW'(out_d);
            pc_d     = redirect_pc_i;
        end else begin
            overflow = credit_sum > SUMW'(IB_DEPTH);
            credit_d = sat_credit(credit_sum);
            if (rsp_pop && (stale_q != '0))
                stale_d = stale_q - 1'b1;
            if (req_fire)
                pc_d = align_pc(pc_q) + PLEN'(GBYTES);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            credit_q    <= CRW'(IB_DEPTH);
            out_q       <= '0;
            stale_q     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            credit_q <= credit_d;
            out_q    <= out_d;
            stale_q  <= stale_d;
            if (req_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rsp_pop)  rd_ptr <= rd_ptr + 1'b1;
            if ((rsp_valid_i && (out_q == '0)) || (fe_valid_o && !fe_ready_i) || overflow)
                proto_err_q <= 1'b1;
        end
    end

    // The unaligned PC is stored so the first group after a redirect keeps its offset.
    always_ff @(posedge clk_i) begin
        if (req_fire) fifo_mem[wr_ptr] <= pc_q;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fetch_en_i)  state_next = FETCH;
            FETCH:   if (!fetch_en_i) state_next = IDLE;
            DRAIN:   if (stale_q == '0) state_next = fetch_en_i ? FETCH : IDLE;
            default: state_next = IDLE;
        endcase
        if (redirect_valid_i)
            state_next = (out_d != '0) ? DRAIN : (fetch_en_i ? FETCH : IDLE);
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_valid_o = (state == FETCH) && (credit_q >= CRW'(FW))
                   && (out_q < OUTW'(MAX_OUTSTANDING));
        req_pc_o    = align_pc(pc_q);
        head_pc     = fifo_mem[rd_ptr];
        fe_valid_o  = fwd;
        fe_instrs_o = rsp_instrs_i;
        fe_pc_o     = align_pc(head_pc);
        slot_idx    = head_pc[OB-1:0] >> IBB;
        fe_slot_valid_o = '0;
        fe_pred_npc_o   = '0;
        for (int i = 0; i < int'(FW); i++) begin
            fe_slot_valid_o[i]          = (OB'(i) >= slot_idx);
            fe_pred_npc_o[i*PLEN +: PLEN] = fe_pc_o + PLEN'(IBYTES * (i + 1));
        end
    end

    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_fetch_credit_ctrl.sv
module tb_fetch_credit_ctrl;
    localparam int FW   = 4;
    localparam int ILEN = 32;
    localparam int PLEN = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 fetch_en;
    logic                 req_valid;
    logic                 req_ready;
    logic [PLEN-1:0]      req_pc;
    logic                 rsp_valid;
    logic [FW*ILEN-1:0]   rsp_instrs;
    logic                 fe_valid;
    logic                 fe_ready;
    logic [FW*ILEN-1:0]   fe_instrs;
    logic [PLEN-1:0]      fe_pc;
    logic [FW-1:0]        fe_slot_valid;
    logic [FW*PLEN-1:0]   fe_pred_npc;
    logic                 deq_fire;
    logic                 redirect_valid;
    logic [PLEN-1:0]      redirect_pc;
    logic                 proto_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_credit_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .fetch_en_i       (fetch_en),
        .req_valid_o      (req_valid),
        .req_ready_i      (req_ready),
        .req_pc_o         (req_pc),
        .rsp_valid_i      (rsp_valid),
        .rsp_instrs_i     (rsp_instrs),
        .fe_valid_o       (fe_valid),
        .fe_ready_i       (fe_ready),
        .fe_instrs_o      (fe_instrs),
        .fe_pc_o          (fe_pc),
        .fe_slot_valid_o  (fe_slot_valid),
        .fe_pred_npc_o    (fe_pred_npc),
        .deq_fire_i       (deq_fire),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .proto_err_o      (proto_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int  issued;
        int  forwarded;
        logic fired_prev;
        logic exp_v;

        rst = 1'b1; fetch_en = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        rsp_instrs = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        fe_ready = 1'b1; deq_fire = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state
        tick;
        chk("rst_req_valid", 64'(req_valid), 64'(0));
        chk("rst_fe_valid",  64'(fe_valid),  64'(0));
        chk("rst_proto_err", 64'(proto_err), 64'(0));
        chk("rst_req_pc",    64'(req_pc),    64'h8000_0000);
        chk("rst_credit",    64'(dut.credit_q), 64'd32);
        rst = 1'b0;

        // Back-to-back issue without responses: four requests, then outstanding limit.
        fetch_en = 1'b1; req_ready = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t1_req_valid", 64'(req_valid), 64'(1));
            chk("t1_req_pc", 64'(req_pc), 64'(32'h8000_0000 + 32'(16 * i)));
            tick;
        end
        #1;
        chk("t1_stall_valid", 64'(req_valid), 64'(0));
        chk("t1_credit", 64'(dut.credit_q), 64'd16);

        // Immediate responses, no dequeue: eight groups, then credit exhaustion.
        rst = 1'b1; tick; rst = 1'b0; tick;
        issued = 0; forwarded = 0; fired_prev = 1'b0;
        for (int c = 0; c < 10; c++) begin
            rsp_valid = fired_prev;
            #1;
            exp_v = (issued < 8);
            chk("t2_req_valid", 64'(req_valid), 64'(exp_v));
            chk("t2_fe_valid", 64'(fe_valid), 64'(rsp_valid));
            if (rsp_valid) begin
                chk("t2_fe_pc", 64'(fe_pc), 64'(32'h8000_0000 + 32'(16 * forwarded)));
                if (forwarded == 0) begin
                    chk("t2_slot_mask", 64'(fe_slot_valid), 64'(4'hF));
                    chk("t2_pred_npc3", 64'(fe_pred_npc[3*PLEN +: PLEN]), 64'h8000_0010);
                end
                forwarded++;
            end
            if (exp_v) begin
                chk("t2_req_pc", 64'(req_pc), 64'(32'h8000_0000 + 32'(16 * issued)));
                issued++;
            end
            fired_prev = exp_v;
            tick;
        end
        rsp_valid = 1'b0;
        #1;
        chk("t2_credit_zero", 64'(dut.credit_q), 64'd0);
        deq_fire = 1'b1; tick; deq_fire = 1'b0;
        #1;
        chk("t2_deq_valid", 64'(req_valid), 64'(1));
        chk("t2_deq_pc", 64'(req_pc), 64'h8000_0080);
        chk("t2_deq_credit", 64'(dut.credit_q), 64'd4);

        // Redirect with three requests outstanding.
        rst = 1'b1; tick; rst = 1'b0; tick;
        tick; tick; tick;
        req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_1008;
        #1;
        chk("t3_redir_fe_valid", 64'(fe_valid), 64'(0));
        tick;
        redirect_valid = 1'b0; req_ready = 1'b1;
        #1;
        chk("t3_drain_credit", 64'(dut.credit_q), 64'd20);
        chk("t3_drain_noreq", 64'(req_valid), 64'(0));
        for (int k = 0; k < 3; k++) begin
            rsp_valid = 1'b1;
            #1;
            chk("t3_drop_fe_valid", 64'(fe_valid), 64'(0));
            chk("t3_drop_noreq", 64'(req_valid), 64'(0));
            tick;
        end
        rsp_valid = 1'b0;
        #1;
        chk("t3_drain_last_noreq", 64'(req_valid), 64'(0));
        tick;
        chk("t3_restart_valid", 64'(req_valid), 64'(1));
        chk("t3_restart_pc", 64'(req_pc), 64'h8000_1000);
        tick;
        req_ready = 1'b0; rsp_valid = 1'b1;
        #1;
        chk("t3_first_fe_valid", 64'(fe_valid), 64'(1));
        chk("t3_first_fe_pc", 64'(fe_pc), 64'h8000_1000);
        chk("t3_first_mask", 64'(fe_slot_valid), 64'(4'b1100));
        chk("t3_first_npc2", 64'(fe_pred_npc[2*PLEN +: PLEN]), 64'h8000_100C);
        chk("t3_next_req_pc", 64'(req_pc), 64'h8000_1010);
        tick;
        rsp_valid = 1'b0;

        // Redirect and response in the same cycle, one outstanding.
        req_ready = 1'b1; tick;
        req_ready = 1'b0; rsp_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
        #1;
        chk("t4_fe_valid", 64'(fe_valid), 64'(0));
        tick;
        rsp_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        chk("t4_credit", 64'(dut.credit_q), 64'd32);
        chk("t4_fetch_valid", 64'(req_valid), 64'(1));
        chk("t4_req_pc", 64'(req_pc), 64'h8000_2000);
        chk("t4_proto_err", 64'(proto_err), 64'(0));

        // Reset mid-operation with two outstanding.
        req_ready = 1'b1; tick; tick;
        req_ready = 1'b0;
        #1;
        chk("t5_pre_credit", 64'(dut.credit_q), 64'd24);
        rst = 1'b1; tick;
        chk("t5_req_pc", 64'(req_pc), 64'h8000_0000);
        chk("t5_credit", 64'(dut.credit_q), 64'd32);
        chk("t5_fe_valid", 64'(fe_valid), 64'(0));
        chk("t5_proto_err", 64'(proto_err), 64'(0));
        chk("t5_req_valid", 64'(req_valid), 64'(0));
        rst = 1'b0;

        // Response with nothing outstanding: sticky error.
        fetch_en = 1'b0; rsp_valid = 1'b1;
        #1;
        chk("t6_err_before", 64'(proto_err), 64'(0));
        tick;
        rsp_valid = 1'b0;
        #1;
        chk("t6_err_set", 64'(proto_err), 64'(1));
        tick; tick;
        chk("t6_err_sticky", 64'(proto_err), 64'(1));
        rst = 1'b1; tick; rst = 1'b0;
        chk("t6_err_cleared", 64'(proto_err), 64'(0));

        // Forwarding into a buffer that is not ready is also an error.
        fetch_en = 1'b1; req_ready = 1'b1; tick; tick;
        req_ready = 1'b0; rsp_valid = 1'b1; fe_ready = 1'b0;
        #1;
        chk("t7_fe_valid", 64'(fe_valid), 64'(1));
        tick;
        rsp_valid = 1'b0; fe_ready = 1'b1;
        #1;
        chk("t7_err_set", 64'(proto_err), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_credit_ctrl.md
Name: fetch_credit_ctrl

Overview:
Fetch sequencer that sits between the instruction-cache fetch port and the instruction buffer. It generates fetch-group-aligned request PCs and reserves instruction-buffer space with entry credits before each request is issued. It tags in-order cache responses with their PC and slot mask and forwards them to the instruction buffer. On a backend redirect it discards stale in-flight responses and restarts fetch at the new PC.

Parameters:
Cfg, config_pkg::EmptyCfg, core config; uses Cfg.INSTR_PER_FETCH (FW), Cfg.ILEN, Cfg.PLEN
IB_DEPTH, 32, instruction-buffer entries; power of two and a multiple of FW
DECODE_WIDTH, Cfg.INSTR_PER_FETCH, entries returned per dequeue pulse
MAX_OUTSTANDING, 4, maximum cache requests in flight; power of two
RESET_PC, 32'h8000_0000, fetch PC after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
fetch_en_i  in  1  permits issue of new requests
req_valid_o  out  1  cache request valid
req_ready_i  in  1  cache accepts request
req_pc_o  out  PLEN  request PC, aligned to FW*ILEN/8 bytes
rsp_valid_i  in  1  in-order cache response; always accepted
rsp_instrs_i  in  FW*ILEN  response instructions
fe_valid_o  out  1  group valid to instruction buffer
fe_ready_i  in  1  instruction-buffer ready (used for checking only)
fe_instrs_o  out  FW*ILEN  group instructions
fe_pc_o  out  PLEN  group base PC (aligned)
fe_slot_valid_o  out  FW  per-slot valid mask
fe_pred_npc_o  out  FW*PLEN  per-slot predicted next PC
deq_fire_i  in  1  instruction buffer popped DECODE_WIDTH entries
redirect_valid_i  in  1  redirect; same cycle as the instruction-buffer flush
redirect_pc_i  in  PLEN  redirect target
proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset values: state=IDLE, pc_q=RESET_PC, credit_q=IB_DEPTH, out_q=0, stale_q=0, PC FIFO empty, proto_err_o=0. All valid outputs are 0 in the cycle after rst_i is sampled high.
- Widths: credit_q uses clog2(IB_DEPTH+1) bits; out_q and stale_q use clog2(MAX_OUTSTANDING+1) bits.
- FSM:
  - IDLE -> FETCH when fetch_en_i=1.
  - FETCH -> IDLE when fetch_en_i=0; requests already in flight still complete and are forwarded.
  - Any state -> DRAIN on redirect_valid_i when the post-update out_d is non-zero; otherwise -> FETCH (or IDLE if fetch_en_i=0).
  - DRAIN -> FETCH/IDLE in the cycle after stale_q reaches 0.
- req_valid_o = (state==FETCH) && credit_q>=FW && out_q<MAX_OUTSTANDING.
  - req_pc_o = pc_q with the low clog2(FW*ILEN/8) bits cleared.
  - On req fire: pc_q += FW*ILEN/8 (aligned), credit -= FW, out += 1, push {pc_q} into the PC FIFO.
- Response handling:
  - rsp_valid_i: out -= 1 and pop the PC FIFO.
  - If stale_q>0 or redirect_valid_i: the response is dropped, stale -= 1 (when stale_q>0), credit += FW.
  - Otherwise fe_valid_o=1 in the same cycle (combinational), with:
    - fe_pc_o = aligned popped PC
    - fe_slot_valid_o[i] = (i >= popped PC offset/(ILEN/8))
    - fe_pred_npc_o[i] = fe_pc_o + (ILEN/8)*(i+1)
- deq_fire_i (no redirect in the same cycle): credit += DECODE_WIDTH.
- Redirect cycle:
  - out_d = out_q + req_fire - rsp_valid_i.
  - A request firing in this cycle and all older requests are stale.
  - stale_d = out_d; credit_d = IB_DEPTH - FW*out_d; deq_fire_i is ignored.
  - pc_q <- redirect_pc_i, unaligned; the offset is kept for the first-group slot mask.
  - PC-FIFO entries still drain in order.
- Slot mask: applied only to the first group after a redirect or reset. Later groups use an all-ones mask.
- A redirect arriving while in DRAIN re-arms stale per the same rule.
- proto_err_o is set (sticky until reset) when any of these occur:
  - rsp_valid_i with out_q==0
  - fe_valid_o && !fe_ready_i
  - credit overflow above IB_DEPTH
- Reset mid-operation discards all state. The cache must be reset in the same cycle.

Test Plan:
- FW=4, IB_DEPTH=32, MAX_OUTSTANDING=4; reset, fetch_en=1, req_ready=1, no responses -> req_pc_o 0x8000_0000, 0x8000_0010, 0x8000_0020, 0x8000_0030 on 4 consecutive cycles, then req_valid_o=0.
- Responses returned immediately, deq_fire_i=0 -> exactly 8 groups issued and forwarded, then stall with credit 0. One deq_fire_i -> one further request, at 0x8000_0080.
- 3 requests outstanding, redirect to 0x8000_1008:
  - Next 3 responses are dropped, with fe_valid_o=0.
  - No request while in DRAIN.
  - Then req_pc_o=0x8000_1000; its group has fe_slot_valid_o=4'b1100 and fe_pred_npc_o[2]=0x8000_100C.
- redirect_valid_i and rsp_valid_i in the same cycle, 1 outstanding -> response dropped, fe_valid_o=0, credit_q=32, next state FETCH.
- rst_i asserted with 2 outstanding and credit 24 -> next cycle req_pc_o=0x8000_0000, credit_q=32, fe_valid_o=0, proto_err_o=0.
- rsp_valid_i with 0 outstanding -> proto_err_o=1 from the next cycle until reset.
